// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pin arbiter.
package uio_arb_pkg;

   localparam int UIO_W = 8;

   typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

   function automatic int clog2_safe(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_picker.sv
// Rotating-priority find-first: first set request at or above ptr, wrapping.
module rr_picker
   import uio_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  winner,
   output logic             any_req
);

   int unsigned idx;

   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr) + i) % N_REQ;
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            winner  = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbitration of the 8 uio pins with an all-input turnaround.
// Optional forced release on hold timeout: define UIO_ARB_TIMEOUT_EN.
module uio_bus_arbiter
   import uio_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TURN_CYCLES = 1,
   parameter int MAX_HOLD    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ena,
   input  logic [N_REQ-1:0]              req,
   input  logic [UIO_W*N_REQ-1:0]        oe_mask,
   input  logic [UIO_W*N_REQ-1:0]        wdata,
   output logic [N_REQ-1:0]              grant,
   output logic [clog2_safe(N_REQ)-1:0]  owner_id,
   output logic                          busy,
   output logic [UIO_W-1:0]              rd_data,
   input  logic [UIO_W-1:0]              uio_in,
   output logic [UIO_W-1:0]              uio_out,
   output logic [UIO_W-1:0]              uio_oe
);

   localparam int ID_W = clog2_safe(N_REQ);
   localparam logic [2:0] TURN_LAST = 3'(TURN_CYCLES - 1);

   state_t            state_q, state_d;
   logic [N_REQ-1:0]  grant_d;
   logic [ID_W-1:0]   owner_d, rr_q, rr_d, winner;
   logic              busy_d, any_req, own_req, release_now;
   logic [UIO_W-1:0]  out_d, oe_d, mask_sel, data_sel;
   logic [2:0]        turn_q, turn_d;
   logic [N_REQ-1:0]  req_m;

`ifdef UIO_ARB_TIMEOUT_EN
   logic [7:0] hold_q, hold_d;
`endif

   assign req_m    = ena ? req : '0;
   assign own_req  = req[owner_id];
   assign mask_sel = oe_mask[int'(owner_id)*UIO_W +: UIO_W];
   assign data_sel = wdata[int'(owner_id)*UIO_W +: UIO_W];

   rr_picker #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_picker (
      .req     (req_m),
      .ptr     (rr_q),
      .winner  (winner),
      .any_req (any_req)
   );

   // Grant is one-hot on the owner while in OWN, so req & ~grant is "someone else waiting".
   always_comb begin
      release_now = !ena || !own_req;
`ifdef UIO_ARB_TIMEOUT_EN
      if ((hold_q == 8'(MAX_HOLD)) && (|(req & ~grant)))
         release_now = 1'b1;
`endif
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant;
      owner_d = owner_id;
      busy_d  = busy;
      out_d   = uio_out;
      oe_d    = uio_oe;
      rr_d    = rr_q;
      turn_d  = turn_q;
`ifdef UIO_ARB_TIMEOUT_EN
      hold_d  = hold_q;
`endif
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            busy_d  = 1'b0;
            out_d   = '0;
            oe_d    = '0;
            if (any_req) begin
               state_d = TURN;
               owner_d = winner;
               busy_d  = 1'b1;
               turn_d  = '0;
            end
         end
         TURN: begin
            if (!ena || !own_req) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (turn_q == TURN_LAST) begin
               state_d          = OWN;
               grant_d          = '0;
               grant_d[owner_id] = 1'b1;
`ifdef UIO_ARB_TIMEOUT_EN
               hold_d           = '0;
`endif
            end else begin
               turn_d = turn_q + 3'd1;
            end
         end
         OWN: begin
            if (release_now) begin
               state_d = IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
               out_d   = '0;
               oe_d    = '0;
               rr_d    = (owner_id == ID_W'(N_REQ - 1)) ? '0 : owner_id + 1'b1;
            end else begin
               oe_d  = mask_sel;
               out_d = data_sel & mask_sel;
`ifdef UIO_ARB_TIMEOUT_EN
               if (hold_q != 8'(MAX_HOLD))
                  hold_d = hold_q + 8'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         grant    <= '0;
         owner_id <= '0;
         busy     <= 1'b0;
         uio_out  <= '0;
         uio_oe   <= '0;
         rd_data  <= '0;
         rr_q     <= '0;
         turn_q   <= '0;
`ifdef UIO_ARB_TIMEOUT_EN
         hold_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         grant    <= grant_d;
         owner_id <= owner_d;
         busy     <= busy_d;
         uio_out  <= out_d;
         uio_oe   <= oe_d;
         rd_data  <= uio_in;
         rr_q     <= rr_d;
         turn_q   <= turn_d;
`ifdef UIO_ARB_TIMEOUT_EN
         hold_q   <= hold_d;
`endif
      end
   end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed scoreboard bench for uio_bus_arbiter (N_REQ=4, TURN_CYCLES=1).
module tb_uio_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ena = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] oe_mask = '0;
   logic [31:0] wdata = '0;
   logic [7:0]  uio_in = '0;
   logic [3:0]  grant;
   logic [1:0]  owner_id;
   logic        busy;
   logic [7:0]  rd_data, uio_out, uio_oe;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   uio_bus_arbiter #(
      .N_REQ       (4),
      .TURN_CYCLES (1),
      .MAX_HOLD    (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .req      (req),
      .oe_mask  (oe_mask),
      .wdata    (wdata),
      .grant    (grant),
      .owner_id (owner_id),
      .busy     (busy),
      .rd_data  (rd_data),
      .uio_in   (uio_in),
      .uio_out  (uio_out),
      .uio_oe   (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed %h expected none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   initial begin
      int w, zeros, own;
      logic held;

      // reset values
      tick(); tick();
      push("rst_grant", 0); push("rst_busy", 0); push("rst_oe", 0);
      push("rst_out", 0); push("rst_owner", 0); push("rst_rd", 0);
      pop_check(32'(grant)); pop_check(32'(busy)); pop_check(32'(uio_oe));
      pop_check(32'(uio_out)); pop_check(32'(owner_id)); pop_check(32'(rd_data));
      rst = 1'b0;

      // rd_data is a one-cycle registered copy of uio_in
      uio_in = 8'h3C; push("rd_lat", 32'h3C);
      tick(); pop_check(32'(rd_data));

      // single request from requester 2
      req = 4'b0100; wdata[23:16] = 8'hA5; oe_mask[23:16] = 8'hFF;
      push("e0_busy", 1); push("e0_owner", 2); push("e0_grant", 0); push("e0_oe", 0);
      tick();
      pop_check(32'(busy)); pop_check(32'(owner_id)); pop_check(32'(grant)); pop_check(32'(uio_oe));
      push("e1_grant", 32'b0100); push("e1_oe", 0);
      tick(); pop_check(32'(grant)); pop_check(32'(uio_oe));
      push("e2_oe", 32'hFF); push("e2_out", 32'hA5);
      tick(); pop_check(32'(uio_oe)); pop_check(32'(uio_out));
      wdata[23:16] = 8'h5A; oe_mask[23:16] = 8'h0F; uio_in = 8'hC3;
      push("mix_oe", 32'h0F); push("mix_out", 32'h0A); push("rd_own", 32'hC3);
      tick(); pop_check(32'(uio_oe)); pop_check(32'(uio_out)); pop_check(32'(rd_data));
      req = 4'b0000;
      push("drop_grant", 0); push("drop_oe", 0); push("drop_busy", 0);
      tick(); pop_check(32'(grant)); pop_check(32'(uio_oe)); pop_check(32'(busy));

      // requester 3 into OWN, then asynchronous reset mid-cycle
      req = 4'b1000; oe_mask[31:24] = 8'hFF; wdata[31:24] = 8'h77;
      push("r3_owner", 3); tick(); pop_check(32'(owner_id));
      tick();
      push("r3_oe", 32'hFF); tick(); pop_check(32'(uio_oe));
      @(negedge clk); rst = 1'b1; #1;
      push("arst_oe", 0); push("arst_grant", 0); push("arst_busy", 0);
      pop_check(32'(uio_oe)); pop_check(32'(grant)); pop_check(32'(busy));
      req = 4'b0000;
      tick(); rst = 1'b0;

      // round robin with all requesting; each owner keeps 3 OWN cycles
      oe_mask = '1; req = 4'b1111; zeros = 0;
      for (int k = 0; k < 5; k++) begin
         push("rr_grant", 32'(1 << (k % 4)));
         w = 0;
         while (grant == 4'b0000 && w < 12) begin
            tick(); w++;
            if (uio_oe == 8'h00) zeros++;
         end
         pop_check(32'(grant));
         if (k > 0) begin
            push("rr_gap", 1);
            pop_check(32'(zeros >= 2));
         end
         push("rr_drive", 32'hFF);
         tick(); pop_check(32'(uio_oe));
         tick(); tick();
         req[k % 4] = 1'b0;
         push("rr_rel", 0);
         tick(); pop_check(32'(grant));
         zeros = (uio_oe == 8'h00) ? 1 : 0;
         req = 4'b1111;
      end

      // rr_ptr is now 1: abort in TURN must not advance it
      req = 4'b0010;
      push("ab_owner", 1); push("ab_busy", 1);
      tick(); pop_check(32'(owner_id)); pop_check(32'(busy));
      req = 4'b0000;
      push("ab_busy0", 0); push("ab_grant", 0);
      tick(); pop_check(32'(busy)); pop_check(32'(grant));
      push("ab_grant2", 0); tick(); pop_check(32'(grant));
      req = 4'b0011;
      push("ab_next", 1); tick(); pop_check(32'(owner_id));
      push("ab_ngrant", 32'b0010); tick(); pop_check(32'(grant));
      tick();

      // ena low in OWN releases; with ena low nothing is granted
      ena = 1'b0;
      push("en_grant", 0); push("en_busy", 0); push("en_oe", 0);
      tick(); pop_check(32'(grant)); pop_check(32'(busy)); pop_check(32'(uio_oe));
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         push("en_mask", 0);
         tick(); pop_check(32'({grant, busy}));
      end
      ena = 1'b1;
      push("en_owner", 2); tick(); pop_check(32'(owner_id));
      push("en_ngrant", 32'b0100); tick(); pop_check(32'(grant));
      req = 4'b0000;
      push("en_rel", 0); tick(); pop_check(32'(grant));

`ifdef UIO_ARB_TIMEOUT_EN
      // rr_ptr=3; owner 0 with requester 3 pending is forced out when hold hits 16
      req = 4'b0001;
      tick(); tick();
      push("to_g0", 32'b0001); pop_check(32'(grant));
      req = 4'b1001; own = 0;
      while (grant == 4'b0001 && own < 40) begin
         tick(); own++;
      end
      push("to_len", 17); pop_check(32'(own));
      tick(); tick();
      push("to_g3", 32'b1000); pop_check(32'(grant));
      req = 4'b0000; tick();
      req = 4'b0001; tick(); tick();
      held = 1'b1;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (grant != 4'b0001) held = 1'b0;
      end
      push("to_lone", 1); pop_check(32'(held));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
